// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial parity link: receiver states, line levels
// and the parity helper also used by the companion transmitter.
package serial_link_pkg;

  localparam int unsigned MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // XOR reduction of a (zero-padded) bit vector, inverted for odd parity
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] i_bits,
                                     input logic                     i_odd);
    return (^i_bits) ^ i_odd;
  endfunction

endpackage

// File: rtl/serial_parity_receiver_if.sv
// Strobe/line inputs and decoded-word outputs of the serial parity receiver.
interface serial_parity_receiver_if #(
  parameter int unsigned DATA_BITS = 4
);

  logic                 sample_en;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output sample_en, rx,
    input  data, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  sample_en, rx,
    output data, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/serial_parity_receiver_parity_accumulator.sv
// One-bit running XOR of the sampled line, cleared at each start bit.
module parity_accumulator (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_din,
  output logic o_acc
);

  import serial_link_pkg::*;

  logic r_acc;
  logic w_acc_nxt;

  assign w_acc_nxt = parity_of(MAX_DATA_BITS'({r_acc, i_din}), 1'b0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= 1'b0;
    end else if (i_clr) begin
      r_acc <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/serial_parity_receiver.sv
// Frame receiver: start bit, DATA_BITS data bits LSB first, parity, stop.
// Reports the recovered word with parity/framing flags on a one-cycle VALID.
module serial_parity_receiver #(
  parameter int unsigned DATA_BITS  = 4,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  serial_parity_receiver_if.slave  link
);

  import serial_link_pkg::*;

  localparam int unsigned     CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_busy;
  logic                 w_start;
  logic                 w_shift;
  logic                 w_acc_en;
  logic                 w_load;
  logic                 w_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath controls; nothing moves without a sample strobe
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_acc_en    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (link.sample_en && (link.rx == START_LEVEL)) begin
          w_start     = 1'b1;
          w_state_nxt = RX_DATA;
        end
      end
      RX_DATA: begin
        if (link.sample_en) begin
          w_shift  = 1'b1;
          w_acc_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_state_nxt = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (link.sample_en) begin
          w_acc_en    = 1'b1;
          w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (link.sample_en) begin
          w_load      = 1'b1;
          w_state_nxt = (link.rx == STOP_LEVEL) ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (link.sample_en && (link.rx == IDLE_LEVEL)) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shift in at the MSB so the first received bit ends up at bit 0
  generate
    if (DATA_BITS > 1) begin : g_shift_wide
      assign w_shift_nxt = {link.rx, r_shift[DATA_BITS-1:1]};
    end else begin : g_shift_single
      assign w_shift_nxt = link.rx;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= w_shift_nxt;
    end
  end

  parity_accumulator u_parity_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start),
    .i_en    (w_acc_en),
    .i_din   (link.rx),
    .o_acc   (w_acc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_busy  <= (w_state_nxt != RX_IDLE);
      if (w_load) begin
        r_data <= r_shift;
        r_perr <= w_acc ^ ODD_PARITY;
        r_ferr <= (link.rx != STOP_LEVEL);
      end
    end
  end

  assign link.data       = r_data;
  assign link.valid      = r_valid;
  assign link.parity_err = r_perr;
  assign link.frame_err  = r_ferr;
  assign link.busy       = r_busy;

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Bench for serial_parity_receiver: even- and odd-parity instances share one
// stimulus stream; results are compared against a bit-counting model.
module tb_serial_parity_receiver;

  localparam int unsigned DB = 4;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  rec_t q_even[$];
  rec_t q_odd[$];

  always #5 clk = ~clk;

  serial_parity_receiver_if #(.DATA_BITS(DB)) if_e ();
  serial_parity_receiver_if #(.DATA_BITS(DB)) if_o ();

  serial_parity_receiver #(.DATA_BITS(DB), .ODD_PARITY(1'b0)) u_even (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .link    (if_e)
  );

  serial_parity_receiver #(.DATA_BITS(DB), .ODD_PARITY(1'b1)) u_odd (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .link    (if_o)
  );

  // Capture every cycle in which VALID is high
  always @(negedge clk) begin
    if (if_e.valid === 1'b1) q_even.push_back(rec_t'{if_e.data, if_e.parity_err, if_e.frame_err});
    if (if_o.valid === 1'b1) q_odd.push_back(rec_t'{if_o.data, if_o.parity_err, if_o.frame_err});
  end

  // Parity error if the count of ones over data+parity has the wrong evenness
  function automatic logic model_perr(input logic [DB-1:0] d, input logic p, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < int'(DB); i++) ones += int'(d[i]);
    ones += int'(p);
    return logic'((ones % 2) == 1) ^ odd;
  endfunction

  task automatic drive(input logic en, input logic b);
    if_e.sample_en = en;
    if_o.sample_en = en;
    if_e.rx        = b;
    if_o.rx        = b;
    @(negedge clk);
  endtask

  task automatic samp(input logic b, input int gap);
    repeat (gap) drive(1'b0, 1'($urandom));
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop, input int gap);
    samp(1'b0, gap);
    for (int i = 0; i < int'(DB); i++) samp(d[i], gap);
    samp(p, gap);
    samp(stop, gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if ({if_e.data, if_e.valid, if_e.parity_err, if_e.frame_err, if_e.busy} !== '0 ||
        {if_o.data, if_o.valid, if_o.parity_err, if_o.frame_err, if_o.busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: even=%b odd=%b expected all zero",
               {if_e.data, if_e.valid, if_e.parity_err, if_e.frame_err, if_e.busy},
               {if_o.data, if_o.valid, if_o.parity_err, if_o.frame_err, if_o.busy});
    end
    rst_n = 1'b1;
    idle(2);
    q_even.delete();
    q_odd.delete();
  endtask

  task automatic test_basic();
    logic [DB-1:0] v_data  [4] = '{4'b1101, 4'b1101, 4'b0000, 4'b0000};
    logic          v_par   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic          v_pe_ev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic          v_pe_od [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      send_frame(v_data[i], v_par[i], 1'b1, 0);
      idle(2);
      n_checks++;
      if (q_even.size() != 1 || q_odd.size() != 1) begin
        n_errors++;
        $display("FAIL basic%0d_valid_count: even=%0d odd=%0d expected 1", i, q_even.size(), q_odd.size());
      end else begin
        r = q_even.pop_front();
        n_checks++;
        if ({r.data, r.perr, r.ferr} !== {v_data[i], v_pe_ev[i], 1'b0}) begin
          n_errors++;
          $display("FAIL basic%0d_even: got data/perr/ferr=%b expected %b", i,
                   {r.data, r.perr, r.ferr}, {v_data[i], v_pe_ev[i], 1'b0});
        end
        r = q_odd.pop_front();
        n_checks++;
        if ({r.data, r.perr, r.ferr} !== {v_data[i], v_pe_od[i], 1'b0}) begin
          n_errors++;
          $display("FAIL basic%0d_odd: got data/perr/ferr=%b expected %b", i,
                   {r.data, r.perr, r.ferr}, {v_data[i], v_pe_od[i], 1'b0});
        end
      end
      n_checks++;
      if (if_e.data !== v_data[i] || if_e.parity_err !== v_pe_ev[i] || if_e.valid !== 1'b0 || if_e.busy !== 1'b0) begin
        n_errors++;
        $display("FAIL basic%0d_hold: data=%b perr=%b valid=%b busy=%b expected data=%b perr=%b valid=0 busy=0",
                 i, if_e.data, if_e.parity_err, if_e.valid, if_e.busy, v_data[i], v_pe_ev[i]);
      end
      q_even.delete();
      q_odd.delete();
    end
  endtask

  task automatic test_frame_err();
    logic [DB-1:0] d;
    logic          p;
    rec_t          r;
    d = DB'($urandom);
    p = 1'($urandom);
    send_frame(d, p, 1'b0, 0);
    n_checks++;
    if (if_e.busy !== 1'b1 || if_o.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ferr_busy_after_stop: even=%b odd=%b expected 1", if_e.busy, if_o.busy);
    end
    for (int i = 0; i < 10; i++) begin
      samp(1'b0, 0);
      n_checks++;
      if (if_e.busy !== 1'b1 || if_e.valid !== 1'b0) begin
        n_errors++;
        $display("FAIL ferr_low%0d: busy=%b valid=%b expected busy=1 valid=0", i, if_e.busy, if_e.valid);
      end
    end
    samp(1'b1, 0);
    n_checks++;
    if (if_e.busy !== 1'b0 || if_o.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ferr_release: busy even=%b odd=%b expected 0", if_e.busy, if_o.busy);
    end
    idle(8);
    n_checks++;
    if (q_even.size() != 1 || q_odd.size() != 1) begin
      n_errors++;
      $display("FAIL ferr_valid_count: even=%0d odd=%0d expected 1", q_even.size(), q_odd.size());
    end else begin
      r = q_even.pop_front();
      n_checks++;
      if ({r.data, r.perr, r.ferr} !== {d, model_perr(d, p, 1'b0), 1'b1}) begin
        n_errors++;
        $display("FAIL ferr_result: got data/perr/ferr=%b expected %b",
                 {r.data, r.perr, r.ferr}, {d, model_perr(d, p, 1'b0), 1'b1});
      end
    end
    q_even.delete();
    q_odd.delete();
  endtask

  task automatic test_strobe_gap();
    logic [DB-1:0] d;
    logic          p;
    logic          s;
    rec_t          re;
    rec_t          ro;
    for (int f = 0; f < 5; f++) begin
      d = DB'($urandom);
      p = 1'($urandom);
      s = 1'($urandom);
      send_frame(d, p, s, 2);
      samp(1'b1, 2);
      samp(1'b1, 2);
      n_checks++;
      if (q_even.size() != 1 || q_odd.size() != 1) begin
        n_errors++;
        $display("FAIL gap%0d_valid_count: even=%0d odd=%0d expected 1", f, q_even.size(), q_odd.size());
      end else begin
        re = q_even.pop_front();
        ro = q_odd.pop_front();
        n_checks++;
        if ({re.data, re.perr, re.ferr, ro.data, ro.perr, ro.ferr} !==
            {d, model_perr(d, p, 1'b0), ~s, d, model_perr(d, p, 1'b1), ~s}) begin
          n_errors++;
          $display("FAIL gap%0d_result: got %b expected %b", f,
                   {re.data, re.perr, re.ferr, ro.data, ro.perr, ro.ferr},
                   {d, model_perr(d, p, 1'b0), ~s, d, model_perr(d, p, 1'b1), ~s});
        end
      end
      q_even.delete();
      q_odd.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] d;
    logic          p;
    rec_t          r;
    send_frame(4'b1010, 1'b1, 1'b0, 0);
    idle(2);
    q_even.delete();
    q_odd.delete();
    samp(1'b0, 0);
    samp(1'b1, 0);
    samp(1'b0, 0);
    if_e.sample_en = 1'b1;
    if_o.sample_en = 1'b1;
    if_e.rx        = 1'b0;
    if_o.rx        = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({if_e.data, if_e.valid, if_e.parity_err, if_e.frame_err, if_e.busy} !== '0 ||
        {if_o.data, if_o.valid, if_o.parity_err, if_o.frame_err, if_o.busy} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: even=%b odd=%b expected all zero",
               {if_e.data, if_e.valid, if_e.parity_err, if_e.frame_err, if_e.busy},
               {if_o.data, if_o.valid, if_o.parity_err, if_o.frame_err, if_o.busy});
    end
    idle(10);
    n_checks++;
    if (q_even.size() != 0 || q_odd.size() != 0 || if_e.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_no_valid: valids even=%0d odd=%0d busy=%b expected 0 0 0",
               q_even.size(), q_odd.size(), if_e.busy);
    end
    q_even.delete();
    q_odd.delete();
    d = DB'($urandom);
    p = 1'($urandom);
    send_frame(d, p, 1'b1, 0);
    idle(2);
    n_checks++;
    if (q_even.size() != 1) begin
      n_errors++;
      $display("FAIL midreset_next_count: got %0d valids expected 1", q_even.size());
    end else begin
      r = q_even.pop_front();
      n_checks++;
      if ({r.data, r.perr, r.ferr} !== {d, model_perr(d, p, 1'b0), 1'b0}) begin
        n_errors++;
        $display("FAIL midreset_next_frame: got %b expected %b",
                 {r.data, r.perr, r.ferr}, {d, model_perr(d, p, 1'b0), 1'b0});
      end
    end
    q_even.delete();
    q_odd.delete();
  endtask

  task automatic test_back_to_back();
    rec_t exp_e[$];
    rec_t exp_o[$];
    rec_t re;
    rec_t ro;
    logic [DB-1:0] d;
    logic          p;
    for (int f = 0; f < 6; f++) begin
      d = DB'($urandom);
      p = 1'($urandom);
      exp_e.push_back(rec_t'{d, model_perr(d, p, 1'b0), 1'b0});
      exp_o.push_back(rec_t'{d, model_perr(d, p, 1'b1), 1'b0});
      send_frame(d, p, 1'b1, 0);
    end
    idle(3);
    n_checks++;
    if (q_even.size() != 6 || q_odd.size() != 6) begin
      n_errors++;
      $display("FAIL b2b_valid_count: even=%0d odd=%0d expected 6", q_even.size(), q_odd.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        re = q_even.pop_front();
        ro = q_odd.pop_front();
        n_checks++;
        if ({re.data, re.perr, re.ferr, ro.data, ro.perr, ro.ferr} !==
            {exp_e[f].data, exp_e[f].perr, exp_e[f].ferr, exp_o[f].data, exp_o[f].perr, exp_o[f].ferr}) begin
          n_errors++;
          $display("FAIL b2b%0d_result: got %b expected %b", f,
                   {re.data, re.perr, re.ferr, ro.data, ro.perr, ro.ferr},
                   {exp_e[f].data, exp_e[f].perr, exp_e[f].ferr, exp_o[f].data, exp_o[f].perr, exp_o[f].ferr});
        end
      end
    end
    q_even.delete();
    q_odd.delete();
  endtask

  initial begin
    rst_n          = 1'b0;
    if_e.sample_en = 1'b0;
    if_o.sample_en = 1'b0;
    if_e.rx        = 1'b1;
    if_o.rx        = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_strobe_gap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_receiver.md
# serial_parity_receiver

Receiving end of the lab's serial parity link: samples a one-wire bit stream (start bit, DATA_BITS data bits LSB first, parity bit, stop bit) and recovers the data word. It recomputes parity with the same XOR reduction used in the combinational parity experiments and flags parity and framing errors. It sits between the board's serial input pin (already synchronised) and the LED/7-segment display logic.

## Interface

- DATA_BITS, 4: data bits per frame (1..8)
- ODD_PARITY, 0: 0 = even parity (XOR of data and parity bits is 0), 1 = odd parity (XOR is 1)
- CLK  input  1  system clock; all state changes on rising edge
- RST_N  input  1  reset, synchronous, active-low
- SAMPLE_EN  input  1  one-cycle strobe; the line is sampled only in cycles where SAMPLE_EN=1
- RX  input  1  serial line; idle high; pre-synchronised
- DATA  output  DATA_BITS  last received word; held until the next frame completes
- VALID  output  1  one-cycle pulse at frame end
- PARITY_ERR  output  1  parity mismatch for the frame; valid with VALID, held until the next VALID
- FRAME_ERR  output  1  stop bit sampled as 0; valid with VALID, held until the next VALID
- BUSY  output  1  high while in any state other than IDLE

## Operation

- States: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a sample with RX=0, go to DATA and clear the bit counter and the parity accumulator. On a sample with RX=1, stay.
- DATA: each sample shifts RX into the shift register at the MSB, so after DATA_BITS samples bit 0 is the first bit received. Each sample also XORs RX into the accumulator. After the DATA_BITS-th sample, go to PARITY.
- PARITY: one sample, XORed into the accumulator; go to STOP.
- STOP: one sample.
  - Load DATA from the shift register and pulse VALID.
  - PARITY_ERR = accumulator XOR ODD_PARITY.
  - FRAME_ERR = (RX==0).
  - If RX=1, go to IDLE; if RX=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until a sample with RX=1, then go to IDLE. This prevents a stuck-low line from starting back-to-back frames.
- Samples while SAMPLE_EN=0 are ignored completely; RX is a don't-care in those cycles.
- Bit counter width: clog2(DATA_BITS+1). It never wraps within a frame.
- The first DATA bit may be sampled on the SAMPLE_EN strobe immediately following the start bit. There is no mid-bit realignment; bit centring is the strobe generator's job.

## Timing

- Reset values: DATA=0, VALID=0, PARITY_ERR=0, FRAME_ERR=0, BUSY=0, state=IDLE, counter=0, accumulator=0.
- Reset mid-frame aborts the frame. No VALID is produced for the partial frame, and previously held DATA and flags are cleared to 0.
- VALID, DATA and the flags update on the clock edge that consumes the stop-bit sample. Latency from the stop-bit sample cycle to VALID=1 is therefore one edge.
- VALID is high for exactly one cycle per frame, including errored frames.
- BUSY rises on the edge consuming the start bit. It falls on the edge consuming a stop bit of 1, or on the edge leaving WAIT_HIGH.
- Minimum frame length: DATA_BITS+3 strobes. With SAMPLE_EN held at 1, consecutive frames can be received with no idle gap; a start bit may be sampled on the strobe right after a good stop bit.
- RST_N has priority over SAMPLE_EN in the same cycle.

## Structure

- Shared package serial_link_pkg:
  - rx state enum (IDLE, DATA, PARITY, STOP, WAIT_HIGH)
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
  - a parity function (XOR reduction plus an odd/even select), for reuse by the companion transmitter
- One sub-module: parity_accumulator. It is a 1-bit XOR register with clear, enable and data-in inputs, and it reuses the team's xor gate style.
- The FSM, shift register and bit counter live in serial_parity_receiver.

## Test plan

- Reset, then SAMPLE_EN=1 with RX bits 0,1,0,1,1,1,1 (start, data LSB-first 1011, parity 1, stop) in even mode -> DATA=4'b1101, VALID one cycle, PARITY_ERR=0, FRAME_ERR=0.
- Same frame with parity bit 0 -> DATA=4'b1101, PARITY_ERR=1, FRAME_ERR=0.
- ODD_PARITY=1, data 0000, parity 1 -> PARITY_ERR=0. Repeat with parity 0 -> PARITY_ERR=1.
- Stop bit 0, followed by RX held 0 for 10 strobes, then 1 -> FRAME_ERR=1 with VALID; BUSY stays 1 until the first 1 sample, and no new frame starts while the line is low.
- SAMPLE_EN pulsed every 3rd cycle with RX toggling randomly between strobes -> the result matches the strobe-only samples, and VALID appears exactly once.
- RST_N=0 asserted after the 2nd data bit, then released -> all outputs 0, BUSY=0, no VALID. A following full frame decodes correctly.
